// File: rtl/npc_pkg.sv
// Shared encodings and constants for the npc fetch pipeline.
package npc_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  localparam logic [63:0] RESET_PC_DEF        = 64'h8000_0000;
  localparam logic [62:0] ECODE_INST_MISALIGN = 63'd0;
  localparam logic [31:0] NOP_INST            = 32'h0000_0013;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory, decode handshake and redirect signals of the fetch stage.
interface if_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_to_id_valid;
  logic        id_allow_in;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        br_taken;
  logic [63:0] br_target;
  logic        flush;
  logic [63:0] flush_target;
  logic        id_inst_cancel;
  logic        if_ex;
  logic [62:0] if_ecode;

  modport master (
    output imem_req, imem_addr, if_to_id_valid, if_pc, if_inst,
           id_inst_cancel, if_ex, if_ecode,
    input  imem_gnt, imem_rvalid, imem_rdata, id_allow_in,
           br_taken, br_target, flush, flush_target
  );

  modport slave (
    input  imem_req, imem_addr, if_to_id_valid, if_pc, if_inst,
           id_inst_cancel, if_ex, if_ecode,
    output imem_gnt, imem_rvalid, imem_rdata, id_allow_in,
           br_taken, br_target, flush, flush_target
  );
endinterface

// File: rtl/if_stage_pc_gen.sv
// Fetch PC register: redirect has priority over the sequential +4 step.
module if_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [63:0] target,
  output logic [63:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect)
      pc <= target;
    else if (advance)
      pc <= pc + 64'd4;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, single-entry buffer to decode.
// Optional fetch-misalignment trap when IFU_MISALIGN_CHK_EN is defined.
//
// state   | meaning
// IF_IDLE | request pc from imem (suppressed while redirecting)
// IF_WAIT | request granted, waiting for rvalid; drop marks a stale response
// IF_HOLD | instruction (or misalign exception) presented to decode
module if_stage
  import npc_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);

  if_state_e   state_q, state_d;
  logic        drop_q, drop_d;
  logic        ex_q, ex_d;
  logic [63:0] pc_q, pc_q_d;
  logic [31:0] inst_q, inst_q_d;
  logic [63:0] pc;
  logic [63:0] target;
  logic        redirect;
  logic        misalign;
  logic        advance;
  logic        req;
  logic        valid;

  assign redirect = bus.flush | bus.br_taken;
  assign target   = bus.flush ? bus.flush_target : bus.br_target;

`ifdef IFU_MISALIGN_CHK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign advance = req & bus.imem_gnt;

  if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .redirect (redirect),
    .target   (target),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_IDLE;
      drop_q  <= 1'b0;
      ex_q    <= 1'b0;
      pc_q    <= 64'd0;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      ex_q    <= ex_d;
      pc_q    <= pc_q_d;
      inst_q  <= inst_q_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    ex_d     = ex_q;
    pc_q_d   = pc_q;
    inst_q_d = inst_q;
    req      = 1'b0;
    valid    = 1'b0;
    case (state_q)
      IF_IDLE: begin
        req = ~redirect & ~misalign & ~rst;
        if (!redirect) begin
          if (misalign) begin
            state_d  = IF_HOLD;
            ex_d     = 1'b1;
            pc_q_d   = pc;
            inst_q_d = NOP_INST;
          end else if (req && bus.imem_gnt) begin
            state_d = IF_WAIT;
            pc_q_d  = pc;
          end
        end
      end
      IF_WAIT: begin
        if (bus.imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = IF_IDLE;
          end else begin
            inst_q_d = bus.imem_rdata;
            ex_d     = 1'b0;
            state_d  = IF_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      IF_HOLD: begin
        valid = ~redirect & ~rst;
        // A misalign exception parks here until a redirect clears it.
        if (redirect) begin
          ex_d    = 1'b0;
          state_d = IF_IDLE;
        end else if (!ex_q && bus.id_allow_in) begin
          state_d = IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  assign bus.imem_req       = req;
  assign bus.imem_addr      = pc;
  assign bus.if_to_id_valid = valid;
  assign bus.if_pc          = pc_q;
  assign bus.if_inst        = inst_q;
  assign bus.id_inst_cancel = redirect;
  assign bus.if_ex          = ex_q;
  assign bus.if_ecode       = ECODE_INST_MISALIGN;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1-cycle (optionally 2-cycle) instruction memory model.
module tb_if_stage;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage #(.RESET_PC(64'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic        mem_late = 1'b0;
  logic        d1 = 1'b0, d2 = 1'b0;
  logic [63:0] a1 = 64'd0, a2 = 64'd0;

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // one clock: grant any request, then present the response one (or two) cycles later
  task automatic tick();
    logic        g;
    logic [63:0] ga;
    #1;
    bus.imem_gnt = bus.imem_req;
    #1;
    g  = bus.imem_req & bus.imem_gnt;
    ga = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_gnt = 1'b0;
    d2 = d1; a2 = a1;
    d1 = g;  a1 = ga;
    bus.imem_rvalid = mem_late ? d2 : d1;
    bus.imem_rdata  = inst_of(mem_late ? a2 : a1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.imem_gnt     = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = 32'd0;
    bus.id_allow_in  = 1'b1;
    bus.br_taken     = 1'b0;
    bus.br_target    = 64'd0;
    bus.flush        = 1'b0;
    bus.flush_target = 64'd0;
    tick();
    tick();

    settle();
    check("rst_req",    bus.imem_req, 0);
    check("rst_valid",  bus.if_to_id_valid, 0);
    check("rst_addr",   bus.imem_addr, 64'h8000_0000);
    check("rst_cancel", bus.id_inst_cancel, 0);
    check("rst_ex",     bus.if_ex, 0);
    check("rst_ecode",  bus.if_ecode, 0);
    check("rst_pc",     bus.if_pc, 0);
    check("rst_inst",   bus.if_inst, 0);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      settle();
      check("seq_req",  bus.imem_req, 1);
      check("seq_addr", bus.imem_addr, 64'h8000_0000 + 64'(4 * k));
      tick();
      settle();
      check("seq_wait_req", bus.imem_req, 0);
      tick();
      settle();
      check("seq_valid", bus.if_to_id_valid, 1);
      check("seq_pc",    bus.if_pc, 64'h8000_0000 + 64'(4 * k));
      check("seq_inst",  bus.if_inst, inst_of(64'h8000_0000 + 64'(4 * k)));
      tick();
    end

    bus.id_allow_in = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      check("stall_valid", bus.if_to_id_valid, 1);
      check("stall_inst",  bus.if_inst, inst_of(64'h8000_000C));
      check("stall_req",   bus.imem_req, 0);
      tick();
    end
    bus.id_allow_in = 1'b1;
    tick();

    settle();
    check("br_pre_addr", bus.imem_addr, 64'h8000_0010);
    mem_late = 1'b1;
    tick();
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h8000_0100;
    settle();
    check("br_cancel", bus.id_inst_cancel, 1);
    check("br_req",    bus.imem_req, 0);
    tick();
    bus.br_taken = 1'b0;
    settle();
    check("br_cancel_off", bus.id_inst_cancel, 0);
    check("br_drop_valid", bus.if_to_id_valid, 0);
    tick();
    mem_late = 1'b0;
    settle();
    check("br_req2",  bus.imem_req, 1);
    check("br_addr",  bus.imem_addr, 64'h8000_0100);
    check("br_valid", bus.if_to_id_valid, 0);
    tick();
    tick();
    settle();
    check("br_hold_pc",   bus.if_pc, 64'h8000_0100);
    check("br_hold_inst", bus.if_inst, inst_of(64'h8000_0100));
    tick();

    bus.flush        = 1'b1;
    bus.flush_target = 64'h8000_0040;
    bus.br_taken     = 1'b1;
    bus.br_target    = 64'h8000_0100;
    settle();
    check("fl_req",    bus.imem_req, 0);
    check("fl_cancel", bus.id_inst_cancel, 1);
    tick();
    bus.flush    = 1'b0;
    bus.br_taken = 1'b0;
    settle();
    check("fl_addr", bus.imem_addr, 64'h8000_0040);
    check("fl_req2", bus.imem_req, 1);
    tick();
    tick();
    settle();
    check("fl_hold_pc", bus.if_pc, 64'h8000_0040);
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h8000_0200;
    settle();
    check("hold_br_valid",  bus.if_to_id_valid, 0);
    check("hold_br_cancel", bus.id_inst_cancel, 1);
    tick();
    bus.br_taken = 1'b0;
    settle();
    check("hold_br_req",   bus.imem_req, 1);
    check("hold_br_addr",  bus.imem_addr, 64'h8000_0200);
    check("hold_br_valid2", bus.if_to_id_valid, 0);
    tick();
    tick();
    tick();

    mem_late = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_late = 1'b0;
    settle();
    check("wrst_valid", bus.if_to_id_valid, 0);
    check("wrst_req",   bus.imem_req, 1);
    check("wrst_addr",  bus.imem_addr, 64'h8000_0000);
    tick();
    tick();
    settle();
    check("wrst_hold_pc",   bus.if_pc, 64'h8000_0000);
    check("wrst_hold_inst", bus.if_inst, inst_of(64'h8000_0000));
    tick();

    bus.br_taken  = 1'b1;
    bus.br_target = 64'h8000_0102;
    tick();
    bus.br_taken = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    settle();
    check("mis_req", bus.imem_req, 0);
    tick();
    settle();
    check("mis_valid", bus.if_to_id_valid, 1);
    check("mis_ex",    bus.if_ex, 1);
    check("mis_ecode", bus.if_ecode, 0);
    check("mis_pc",    bus.if_pc, 64'h8000_0102);
    check("mis_inst",  bus.if_inst, 32'h0000_0013);
    tick();
    tick();
    tick();
    settle();
    check("mis_held_valid", bus.if_to_id_valid, 1);
    check("mis_held_ex",    bus.if_ex, 1);
    check("mis_held_req",   bus.imem_req, 0);
    bus.flush        = 1'b1;
    bus.flush_target = 64'h8000_0000;
    settle();
    check("mis_fl_valid", bus.if_to_id_valid, 0);
    tick();
    bus.flush = 1'b0;
    settle();
    check("mis_fl_req",  bus.imem_req, 1);
    check("mis_fl_addr", bus.imem_addr, 64'h8000_0000);
    check("mis_fl_ex",   bus.if_ex, 0);
`else
    settle();
    check("nomis_req",  bus.imem_req, 1);
    check("nomis_addr", bus.imem_addr, 64'h8000_0102);
    check("nomis_ex",   bus.if_ex, 0);
    tick();
    tick();
    settle();
    check("nomis_pc", bus.if_pc, 64'h8000_0102);
    check("nomis_ex2", bus.if_ex, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
